best_arr_send_ctrl: RTL and testbench

- Output scheduler between the best-match result arrays (best index, best distance) and the 11-bit output FIFO that drives the chip pins.
- On a `send_best_arr` request it walks all NUM_QUERYS results in the blocked pixel order expected off-chip.
- It streams every index word first, then every distance as two 11-bit words, and flags `send_done` at the end.
- It applies FIFO backpressure and owns the single read port of the result arrays while active.

---
 rtl/best_arr_send_ctrl.sv | 149 ++++++++++++++
 tb/tb_best_arr_send_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/best_arr_send_ctrl.sv
// Streams the best-match result arrays to the 11-bit output FIFO in blocked pixel
// order: every index word first, then every distance as a low/high word pair.
module best_arr_send_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int ROW_SIZE   = 32,
  parameter int COL_SIZE   = 16,
  parameter int BLOCKING   = 4,
  parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
  parameter int ADDR_WIDTH = $clog2(NUM_QUERYS)
) (
  input  logic                    io_clk,
  input  logic                    io_rst_n,
  input  logic                    send_best_arr,
  output logic                    busy,
  output logic                    send_done,
  output logic                    arr_rd_en,
  output logic [ADDR_WIDTH-1:0]   arr_rd_addr,
  input  logic [DATA_WIDTH-1:0]   arr_rd_idx,
  input  logic [2*DATA_WIDTH-1:0] arr_rd_dist,
  output logic                    out_fifo_wenq,
  output logic [DATA_WIDTH-1:0]   out_fifo_wdata,
  input  logic                    out_fifo_wfull_n
);

  localparam int XI_W  = $clog2(BLOCKING);
  localparam int Y_W   = $clog2(COL_SIZE);
  localparam int X_W   = $clog2(ROW_SIZE / 2 / BLOCKING);
  localparam int PX_SH = $clog2(ROW_SIZE / 2);
  localparam int Y_SH  = $clog2(ROW_SIZE);
  localparam int CNT_W = 1 + X_W + Y_W + XI_W;

  typedef enum logic [2:0] {
    IDLE, IDX_RD, IDX_WR, DST_RD, DST_LO, DST_HI, DONE
  } state_t;

  // Fields ordered outermost to innermost, so a plain increment carries
  // innermost-first and wraps to zero after the last entry.
  typedef struct packed {
    logic            px;
    logic [X_W-1:0]  x;
    logic [Y_W-1:0]  y;
    logic [XI_W-1:0] xi;
  } cnt_t;

  state_t                  state_q, state_d;
  cnt_t                    cnt_q, cnt_d;
  logic [2*DATA_WIDTH-1:0] data_q, data_d;
  logic                    rd_en_q;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_en;
  logic                    wenq;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    last_entry;
  logic [ADDR_WIDTH-1:0]   addr;

  assign last_entry = &cnt_q;
  assign addr = (ADDR_WIDTH'(cnt_q.px) << PX_SH) + (ADDR_WIDTH'(cnt_q.y) << Y_SH)
              + (ADDR_WIDTH'(cnt_q.x) << XI_W) + ADDR_WIDTH'(cnt_q.xi);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = done_q;
    rd_en   = 1'b0;
    wenq    = 1'b0;
    wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (send_best_arr) begin
          done_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDX_RD;
        end
      end
      IDX_RD: begin
        rd_en   = 1'b1;
        state_d = IDX_WR;
      end
      IDX_WR: begin
        // Array data is only valid the cycle after the read; later stall cycles use the held copy.
        if (rd_en_q) data_d = {{DATA_WIDTH{1'b0}}, arr_rd_idx};
        wdata = data_d[DATA_WIDTH-1:0];
        if (out_fifo_wfull_n) begin
          wenq    = 1'b1;
          cnt_d   = cnt_t'(cnt_q + CNT_W'(1));
          state_d = last_entry ? DST_RD : IDX_RD;
        end
      end
      DST_RD: begin
        rd_en   = 1'b1;
        state_d = DST_LO;
      end
      DST_LO: begin
        if (rd_en_q) data_d = arr_rd_dist;
        wdata = data_d[DATA_WIDTH-1:0];
        if (out_fifo_wfull_n) begin
          wenq    = 1'b1;
          state_d = DST_HI;
        end
      end
      DST_HI: begin
        wdata = data_q[2*DATA_WIDTH-1:DATA_WIDTH];
        if (out_fifo_wfull_n) begin
          wenq    = 1'b1;
          cnt_d   = cnt_t'(cnt_q + CNT_W'(1));
          state_d = last_entry ? DONE : DST_RD;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge io_clk or negedge io_rst_n) begin
    if (!io_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      rd_en_q <= rd_en;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy           = busy_q;
  assign send_done      = done_q;
  assign arr_rd_en      = rd_en;
  assign arr_rd_addr    = addr;
  assign out_fifo_wenq  = wenq;
  assign out_fifo_wdata = wdata;

endmodule

// File: tb/tb_best_arr_send_ctrl.sv
// Directed bench for best_arr_send_ctrl: array model idx[a]=a, dist[a]=a*3000,
// word/address scoreboard built from the loop nest, with backpressure and reset cases.
module tb_best_arr_send_ctrl;

  localparam int DW = 11;
  localparam int AW = 9;
  localparam int NQ = 512;
  localparam int PASS_CYC = 2561;

  logic          io_clk = 1'b0;
  logic          io_rst_n = 1'b0;
  logic          send_best_arr = 1'b0;
  logic          busy, send_done;
  logic          arr_rd_en;
  logic [AW-1:0] arr_rd_addr;
  logic [DW-1:0] arr_rd_idx;
  logic [2*DW-1:0] arr_rd_dist;
  logic          out_fifo_wenq;
  logic [DW-1:0] out_fifo_wdata;
  logic          out_fifo_wfull_n = 1'b1;

  best_arr_send_ctrl dut (
    .io_clk(io_clk), .io_rst_n(io_rst_n), .send_best_arr(send_best_arr),
    .busy(busy), .send_done(send_done),
    .arr_rd_en(arr_rd_en), .arr_rd_addr(arr_rd_addr),
    .arr_rd_idx(arr_rd_idx), .arr_rd_dist(arr_rd_dist),
    .out_fifo_wenq(out_fifo_wenq), .out_fifo_wdata(out_fifo_wdata),
    .out_fifo_wfull_n(out_fifo_wfull_n)
  );

  always #5 io_clk = ~io_clk;

  // Result arrays: data valid only the cycle after a read, junk otherwise.
  always @(posedge io_clk) begin
    if (arr_rd_en) begin
      arr_rd_idx  <= DW'(arr_rd_addr);
      arr_rd_dist <= 22'(int'(arr_rd_addr) * 3000);
    end else begin
      arr_rd_idx  <= 11'h5A5;
      arr_rd_dist <= 22'h2A5A5A;
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / scoreboard capture
  logic [DW-1:0] words[$];
  logic [AW-1:0] addrs[$];
  int viol = 0;
  int done_rises = 0;
  logic done_prev = 1'b0;

  always @(negedge io_clk) begin
    if (out_fifo_wenq) begin
      words.push_back(out_fifo_wdata);
      if (!out_fifo_wfull_n) viol++;
    end
    if (arr_rd_en) addrs.push_back(arr_rd_addr);
    if (send_done && !done_prev) done_rises++;
    done_prev = send_done;
  end

  // Backpressure: low 5 of every 7 cycles when enabled.
  bit bp_en = 1'b0;
  int bp_cyc = 0;
  initial begin
    forever begin
      @(posedge io_clk);
      #1;
      if (bp_en) begin
        bp_cyc++;
        out_fifo_wfull_n = ((bp_cyc % 7) >= 5);
      end else begin
        out_fifo_wfull_n = 1'b1;
      end
    end
  end

  int exp_addr[NQ];
  logic [DW-1:0] exp_words[3*NQ];

  task automatic clear_mon();
    words.delete();
    addrs.delete();
    viol = 0;
    done_rises = 0;
  endtask

  task automatic step();
    @(posedge io_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(send_done), 0);
    check({tag, "_rd_en"}, 32'(arr_rd_en), 0);
    check({tag, "_rd_addr"}, 32'(arr_rd_addr), 0);
    check({tag, "_wenq"}, 32'(out_fifo_wenq), 0);
    check({tag, "_wdata"}, 32'(out_fifo_wdata), 0);
  endtask

  // Start a pass (start driven for one edge) and return edges from start acceptance to send_done.
  task automatic run_pass(input string tag, input bit pulse_mid, output int lat);
    int n;
    send_best_arr = 1'b1;
    step();
    send_best_arr = 1'b0;
    check({tag, "_busy_at_start"}, 32'(busy), 1);
    check({tag, "_done_cleared"}, 32'(send_done), 0);
    n = 0;
    while (!send_done && n < 20000) begin
      if (pulse_mid && n == 99) send_best_arr = 1'b1;
      step();
      send_best_arr = 1'b0;
      n++;
    end
    if (!send_done) check({tag, "_timeout"}, 0, 1);
    lat = n;
  endtask

  task automatic check_stream(input string tag);
    int bad;
    check({tag, "_nwords"}, 32'(words.size()), 3 * NQ);
    check({tag, "_nreads"}, 32'(addrs.size()), 2 * NQ);
    check({tag, "_enq_while_full"}, 32'(viol), 0);
    bad = 0;
    for (int i = 0; i < words.size() && i < 3 * NQ; i++)
      if (words[i] !== exp_words[i]) bad++;
    check({tag, "_word_mismatches"}, 32'(bad), 0);
    bad = 0;
    for (int i = 0; i < addrs.size() && i < 2 * NQ; i++)
      if (int'(addrs[i]) != exp_addr[i % NQ]) bad++;
    check({tag, "_addr_mismatches"}, 32'(bad), 0);
  endtask

  initial begin
    int k, lat;
    // Expected order from the loop nest, computed arithmetically.
    k = 0;
    for (int px = 0; px < 2; px++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 16; y++)
          for (int xi = 0; xi < 4; xi++) begin
            exp_addr[k] = px * 16 + y * 32 + x * 4 + xi;
            k++;
          end
    for (int i = 0; i < NQ; i++) begin
      int d;
      d = exp_addr[i] * 3000;
      exp_words[i]              = DW'(exp_addr[i]);
      exp_words[NQ + 2 * i]     = DW'(d % 2048);
      exp_words[NQ + 2 * i + 1] = DW'(d / 2048);
    end

    // Reset state
    io_rst_n = 1'b0;
    repeat (3) step();
    check_reset_outputs("reset");
    io_rst_n = 1'b1;
    step();

    // Pass 1: free-running FIFO
    clear_mon();
    run_pass("p1", 1'b0, lat);
    check("p1_latency", 32'(lat), PASS_CYC);
    check_stream("p1");
    check("p1_rd0", 32'(addrs[0]), 0);
    check("p1_rd3", 32'(addrs[3]), 3);
    check("p1_rd4", 32'(addrs[4]), 32);
    check("p1_rd7", 32'(addrs[7]), 35);
    check("p1_rd8", 32'(addrs[8]), 64);
    check("p1_rd60", 32'(addrs[60]), 480);
    check("p1_rd63", 32'(addrs[63]), 483);
    check("p1_rd64", 32'(addrs[64]), 4);
    check("p1_rd256_px1", 32'(addrs[256]), 16);
    check("p1_w1", 32'(words[1]), 1);
    check("p1_dist0_lo", 32'(words[NQ]), 0);
    check("p1_dist0_hi", 32'(words[NQ + 1]), 0);
    check("p1_dist1_lo", 32'(words[NQ + 2]), 32'h3B8);
    check("p1_dist1_hi", 32'(words[NQ + 3]), 32'h1);
    step();
    check("p1_idle_busy", 32'(busy), 0);
    check("p1_done_level", 32'(send_done), 1);

    // Pass 2: backpressure
    clear_mon();
    bp_en = 1'b1;
    bp_cyc = 0;
    run_pass("bp", 1'b0, lat);
    bp_en = 1'b0;
    check_stream("bp");

    // Pass 3: start pulsed mid-pass is ignored
    step();
    clear_mon();
    run_pass("mid", 1'b1, lat);
    check("mid_latency", 32'(lat), PASS_CYC);
    repeat (20) step();
    check("mid_done_count", 32'(done_rises), 1);
    check("mid_no_restart", 32'(busy), 0);
    check_stream("mid");

    // Async reset during the distance phase
    send_best_arr = 1'b1;
    step();
    send_best_arr = 1'b0;
    repeat (1500) step();
    check("rst_mid_busy_before", 32'(busy), 1);
    io_rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    step();
    io_rst_n = 1'b1;
    clear_mon();
    repeat (5) step();
    check("rst_mid_no_words", 32'(words.size()), 0);
    check("rst_mid_no_reads", 32'(addrs.size()), 0);
    run_pass("fresh", 1'b0, lat);
    check("fresh_latency", 32'(lat), PASS_CYC);
    check_stream("fresh");

    // Back-to-back with start held high
    send_best_arr = 1'b1;
    k = 0;
    step();
    while (!send_done && k < 20000) begin
      step();
      k++;
    end
    check("b2b_first_done", 32'(send_done), 1);
    step();
    check("b2b_done_drops", 32'(send_done), 0);
    check("b2b_busy_again", 32'(busy), 1);
    send_best_arr = 1'b0;
    clear_mon();
    k = 0;
    while (!send_done && k < 20000) begin
      step();
      k++;
    end
    check("b2b_second_latency", 32'(k), PASS_CYC);
    check_stream("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
